// File: rtl/mod_inverse_727_pkg.sv
// gf727_pkg: field constants and FSM state type shared by the GF(727) inverter.
package gf727_pkg;

    localparam int unsigned Q     = 727;   // field modulus
    localparam int unsigned QBITS = 10;    // residue width
    localparam int unsigned MU    = 1442;  // floor(2^20 / Q)

    typedef logic [QBITS-1:0] res_t;

    // Exponent Q-2, scanned MSB first by the square-and-multiply loop.
    localparam res_t EXP   = 10'd725;
    localparam res_t Q_RES = res_t'(Q);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQR,
        S_MUL,
        S_CHK,
        S_DONE
    } state_t;

endpackage

// File: rtl/mod_inverse_727_if.sv
// mod_inverse_727_if: operand/result valid-ready channels of the GF(727) inverter.
interface mod_inverse_727_if;
    import gf727_pkg::*;

    logic din_valid;
    logic din_ready;
    res_t din_a;
    logic dout_valid;
    logic dout_ready;
    res_t dout_r;
    logic zero_err;
    logic chk_fail;

    modport master (
        output din_valid, din_a, dout_ready,
        input  din_ready, dout_valid, dout_r, zero_err, chk_fail
    );

    modport slave (
        input  din_valid, din_a, dout_ready,
        output din_ready, dout_valid, dout_r, zero_err, chk_fail
    );

endinterface

// File: rtl/mod_inverse_727_mulred.sv
// gf727_mulred: combinational 10x10 multiply with Barrett reduction mod 727.
module gf727_mulred
    import gf727_pkg::*;
(
    input  res_t a,
    input  res_t b,
    output res_t r
);

    logic [19:0] prod;
    logic [19:0] hi;
    logic [20:0] t_full;
    logic [19:0] t;
    logic [19:0] s1;
    logic [19:0] s2;
    logic [19:0] s3;

    // Barrett estimate of the quotient, then at most two corrective subtractions.
    always_comb begin
        prod   = 20'(a) * 20'(b);
        hi     = prod >> QBITS;
        t_full = 21'(hi) * 21'(MU);
        t      = 20'(t_full >> QBITS);
        s1     = prod - t * 20'(Q);
        s2     = (s1 >= 20'(Q)) ? s1 - 20'(Q) : s1;
        s3     = (s2 >= 20'(Q)) ? s2 - 20'(Q) : s2;
        r      = res_t'(s3);
    end

endmodule

// File: rtl/mod_inverse_727.sv
// mod_inverse_727: Fermat inverse a^(Q-2) mod 727 by left-to-right square-and-multiply.
// Optional build macro MODINV_SELFCHECK_EN adds a CHK state that verifies acc*base == 1.
module mod_inverse_727
    import gf727_pkg::*;
(
    input logic              clk,
    input logic              rst,
    mod_inverse_727_if.slave bus
);

`ifdef MODINV_SELFCHECK_EN
    localparam state_t LAST_STATE = S_CHK;
`else
    localparam state_t LAST_STATE = S_DONE;
`endif

    state_t     state_q;
    state_t     state_d;
    res_t       acc_q;
    res_t       base_q;
    res_t       base_in;
    res_t       mul_b;
    res_t       mul_r;
    logic [3:0] idx_q;
    logic       zero_q;
    logic       last_bit;
    logic       exp_bit;
`ifdef MODINV_SELFCHECK_EN
    logic       chk_fail_q;
`endif

    // Operand fold, exponent bit lookup and the shared multiplier's operand mux.
    always_comb begin
        base_in  = (bus.din_a >= Q_RES) ? bus.din_a - Q_RES : bus.din_a;
        last_bit = (idx_q == 4'd0);
        exp_bit  = EXP[idx_q];
        mul_b    = (state_q == S_SQR) ? acc_q : base_q;
    end

    gf727_mulred u_mulred (
        .a (acc_q),
        .b (mul_b),
        .r (mul_r)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses <= so all flops sample the pre-edge values together.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: walk EXP from bit 9 down to bit 0.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.din_valid) state_d = S_SQR;
            S_SQR: begin
                if (exp_bit)       state_d = S_MUL;
                else if (last_bit) state_d = LAST_STATE;
            end
            S_MUL:  state_d = last_bit ? LAST_STATE : S_SQR;
            S_CHK:  state_d = S_DONE;
            S_DONE: if (bus.dout_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, accumulator updates and bit index.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset as well so the gated outputs never expose X.
        if (rst) begin
            acc_q      <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            zero_q     <= 1'b0;
`ifdef MODINV_SELFCHECK_EN
            chk_fail_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.din_valid) begin
                        base_q     <= base_in;
                        acc_q      <= res_t'(1);
                        idx_q      <= 4'd9;
                        zero_q     <= (base_in == '0);
`ifdef MODINV_SELFCHECK_EN
                        chk_fail_q <= 1'b0;
`endif
                    end
                end
                S_SQR: begin
                    acc_q <= mul_r;
                    if (!exp_bit && !last_bit) idx_q <= idx_q - 4'd1;
                end
                S_MUL: begin
                    acc_q <= mul_r;
                    if (!last_bit) idx_q <= idx_q - 4'd1;
                end
`ifdef MODINV_SELFCHECK_EN
                S_CHK: chk_fail_q <= !zero_q && (mul_r != res_t'(1));
`endif
                default: ;
            endcase
        end
    end

    // Outputs: handshake flags and result fields, gated to DONE.
    always_comb begin
        bus.din_ready  = (state_q == S_IDLE);
        bus.dout_valid = (state_q == S_DONE);
        bus.dout_r     = (state_q == S_DONE) ? acc_q : '0;
        bus.zero_err   = (state_q == S_DONE) && zero_q;
`ifdef MODINV_SELFCHECK_EN
        bus.chk_fail   = (state_q == S_DONE) && chk_fail_q;
`else
        bus.chk_fail   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mod_inverse_727.sv
// tb_mod_inverse_727: randomized and directed bench against a brute-force GF(727) inverse model.
module tb_mod_inverse_727;

`ifdef MODINV_SELFCHECK_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_inverse_727_if bus ();

    mod_inverse_727 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference: fold mod 727, then search for the x with m*x == 1 (0 maps to 0).
    function automatic int ref_inv(input int a);
        int m;
        m = a % 727;
        if (m == 0) return 0;
        for (int x = 1; x < 727; x++)
            if ((m * x) % 727 == 1) return x;
        return -1;
    endfunction

    // Present one operand and wait (bounded) for dout_valid; dout_ready is left low.
    task automatic do_op(input logic [9:0] a, output logic rdy, output int lat,
                         output logic [9:0] r, output logic z, output logic cf);
        @(negedge clk);
        bus.din_a      = a;
        bus.din_valid  = 1'b1;
        bus.dout_ready = 1'b0;
        rdy = bus.din_ready;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        lat = 0;
        while (bus.dout_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = bus.dout_r;
        z  = bus.zero_err;
        cf = bus.chk_fail;
    endtask

    // Accept the result and confirm the block is back in IDLE the next cycle.
    task automatic release_op(input string tag);
        @(negedge clk);
        bus.dout_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b0;
        n_vec++;
        if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_release: got valid=%b ready=%b want valid=0 ready=1",
                     tag, bus.dout_valid, bus.din_ready);
        end
    endtask

    // One full operation checked against the model.
    task automatic test_op(input logic [9:0] a, input string tag);
        logic rdy, z, cf;
        int lat, exp_r;
        logic [9:0] r;
        exp_r = ref_inv(int'(a));
        do_op(a, rdy, lat, r, z, cf);
        n_vec++;
        if (rdy !== 1'b1) begin
            n_bad++; $display("FAIL %s_ready a=%0d: got %b want 1", tag, a, rdy);
        end
        n_vec++;
        if (lat != LAT) begin
            n_bad++; $display("FAIL %s_latency a=%0d: got %0d want %0d", tag, a, lat, LAT);
        end
        n_vec++;
        if (r !== 10'(exp_r)) begin
            n_bad++; $display("FAIL %s_r a=%0d: got %0d want %0d", tag, a, r, exp_r);
        end
        n_vec++;
        if (z !== ((a % 727) == 0)) begin
            n_bad++; $display("FAIL %s_zero_err a=%0d: got %b want %b", tag, a, z, (a % 727) == 0);
        end
        n_vec++;
        if (cf !== 1'b0) begin
            n_bad++; $display("FAIL %s_chk_fail a=%0d: got %b want 0", tag, a, cf);
        end
        release_op(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.din_valid  = 1'b0;
        bus.din_a      = '0;
        bus.dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.din_ready !== 1'b1 || bus.dout_valid !== 1'b0 || bus.dout_r !== 10'd0 ||
            bus.zero_err !== 1'b0 || bus.chk_fail !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: got ready=%b valid=%b r=%0d z=%b cf=%b want 1 0 0 0 0",
                     bus.din_ready, bus.dout_valid, bus.dout_r, bus.zero_err, bus.chk_fail);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        test_op(10'd2,   "dir2");
        test_op(10'd3,   "dir3");
        test_op(10'd726, "dir726");
        test_op(10'd1,   "dir1");
        test_op(10'd728, "dir728");
        test_op(10'd0,   "dir0");
        test_op(10'd727, "dir727");
        test_op(10'd1023, "dir1023");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            test_op(10'($urandom_range(1023, 0)), "rand");
    endtask

    task automatic test_backpressure();
        logic rdy, z, cf;
        int lat;
        logic [9:0] r;
        bit seen;
        do_op(10'd2, rdy, lat, r, z, cf);
        n_vec++;
        if (r !== 10'd364 || lat != LAT) begin
            n_bad++; $display("FAIL bp_first: got r=%0d lat=%0d want 364 %0d", r, lat, LAT);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.dout_valid !== 1'b1 || bus.dout_r !== 10'd364 || bus.din_ready !== 1'b0 ||
                bus.zero_err !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d: got valid=%b r=%0d ready=%b z=%b want 1 364 0 0",
                         k, bus.dout_valid, bus.dout_r, bus.din_ready, bus.zero_err);
            end
            bus.din_a     = 10'd5;
            bus.din_valid = (k == 2);
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        release_op("bp");
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.dout_valid === 1'b1 || bus.din_ready !== 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_bad++; $display("FAIL bp_ignored_pulse: got activity=1 want 0");
        end
    endtask

    task automatic test_reset_midop();
        bit seen;
        @(negedge clk);
        bus.din_a     = 10'd2;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.din_ready !== 1'b1 || bus.dout_valid !== 1'b0 || bus.dout_r !== 10'd0 ||
            bus.zero_err !== 1'b0 || bus.chk_fail !== 1'b0) begin
            n_bad++;
            $display("FAIL midop_reset: got ready=%b valid=%b r=%0d z=%b cf=%b want 1 0 0 0 0",
                     bus.din_ready, bus.dout_valid, bus.dout_r, bus.zero_err, bus.chk_fail);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.dout_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_bad++; $display("FAIL midop_no_output: got dout_valid=1 want 0");
        end
        test_op(10'd3, "after_reset");
    endtask

    task automatic test_sweep();
        logic rdy, z, cf;
        int lat;
        logic [9:0] r;
        for (int a = 1; a < 727; a++) begin
            do_op(10'(a), rdy, lat, r, z, cf);
            n_vec++;
            if ((a * int'(r)) % 727 != 1 || r !== 10'(ref_inv(a))) begin
                n_bad++; $display("FAIL sweep_r a=%0d: got %0d want %0d", a, r, ref_inv(a));
            end
            n_vec++;
            if (lat != LAT || z !== 1'b0 || cf !== 1'b0) begin
                n_bad++;
                $display("FAIL sweep_flags a=%0d: got lat=%0d z=%b cf=%b want %0d 0 0",
                         a, lat, z, cf, LAT);
            end
            release_op("sweep");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
